// File: rtl/data_stream_tagger_pkg.sv
// data_stream_tagger_pkg
//   Shared types and constants for the data stream tagger.
//   - state_t        : PASS / MARK controller states
//   - marker word    : [31:24] header, [23:0] payload
//   - DEF_MARK_HDR   : default marker header byte
//   - make_marker()  : assembles a marker word from header and payload
package data_stream_tagger_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WCNT_W     = 16;
  localparam int unsigned MCNT_W     = 24;

  localparam int unsigned HDR_MSB    = 31;
  localparam int unsigned HDR_LSB    = 24;
  localparam int unsigned PAY_MSB    = 23;
  localparam int unsigned PAY_LSB    = 0;

  localparam logic [7:0]  DEF_MARK_HDR = 8'hFE;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_MARK = 1'b1
  } state_t;

  function automatic logic [DATA_W-1:0] make_marker(
    input logic [HDR_MSB-HDR_LSB:0] hdr,
    input logic [PAY_MSB-PAY_LSB:0] payload
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[HDR_MSB:HDR_LSB] = hdr;
    w[PAY_MSB:PAY_LSB] = payload;
    return w;
  endfunction

endpackage

// File: rtl/tagger_out_stage.sv
// tagger_out_stage
//   Single registered output stage with valid/ready handshake.
//   Ports:
//     i_clk, i_rst_n  : clock, async active-low reset
//     i_load          : capture i_data this cycle (only asserted when o_free)
//     i_data          : word to capture
//     i_out_ready     : downstream accepts the presented word
//     o_valid, o_data : presented word
//     o_free          : register may be (re)loaded this cycle
module tagger_out_stage
  import data_stream_tagger_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_out_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Free when empty or when the current word leaves this cycle; loads only
  // happen when free, so a stalled word is never overwritten.
  assign o_free  = !r_valid || i_out_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_stream_tagger.sv
// data_stream_tagger
//   Passes 32-bit words from an upstream arbiter to a BRAM FIFO and, when
//   ENABLE is high, inserts a marker word {MARK_HDR, payload} after every
//   MARK_PERIOD data words. Payload is the marker count before increment.
//   Optional macro TAGGER_TIMESTAMP_EN: payload becomes a free-running
//   24-bit BUS_CLK cycle counter sampled on the marker load cycle.
//   Ports:
//     BUS_CLK, BUS_RST_N           : clock, async active-low reset
//     ENABLE                       : marker insertion enable
//     IN_VALID, IN_DATA, IN_READY  : upstream handshake
//     OUT_VALID, OUT_DATA, OUT_READY : downstream handshake
//     MARK_COUNT                   : markers emitted since reset (wraps)
module data_stream_tagger
  import data_stream_tagger_pkg::*;
#(
  parameter int unsigned MARK_PERIOD = 256,
  parameter logic [7:0]  MARK_HDR    = DEF_MARK_HDR
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST_N,
  input  logic              ENABLE,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_DATA,
  input  logic              OUT_READY,
  output logic [MCNT_W-1:0] MARK_COUNT
);

  localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(MARK_PERIOD - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [MCNT_W-1:0]   r_mcnt;
  logic [MCNT_W-1:0]   w_payload;
  logic                w_free;
  logic                w_in_ready;
  logic                w_mark_load;
  logic                w_accept;
  logic                w_load;
  logic [DATA_W-1:0]   w_load_data;
  logic                w_last_word;

  assign w_accept    = IN_VALID && w_in_ready;
  assign w_last_word = ENABLE && (r_wcnt == W_LAST);

  // FSM: state register
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) r_state <= ST_PASS;
    else            r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PASS: if (w_accept && w_last_word) w_state_nxt = ST_MARK;
      ST_MARK: if (w_free)                  w_state_nxt = ST_PASS;
      default:                              w_state_nxt = ST_PASS;
    endcase
  end

  // FSM: outputs. In MARK upstream is held off so no data word can slip
  // ahead of the pending marker.
  always_comb begin
    w_in_ready  = 1'b0;
    w_mark_load = 1'b0;
    case (r_state)
      ST_PASS: w_in_ready  = w_free;
      ST_MARK: w_mark_load = w_free;
      default: w_in_ready  = 1'b0;
    endcase
  end

  // Word counter is held at 0 while disabled, so re-enabling always starts a
  // fresh period.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N)    r_wcnt <= '0;
    else if (!ENABLE)  r_wcnt <= '0;
    else if (w_accept) r_wcnt <= (r_wcnt == W_LAST) ? '0 : r_wcnt + 1'b1;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N)       r_mcnt <= '0;
    else if (w_mark_load) r_mcnt <= r_mcnt + 1'b1;
  end

`ifdef TAGGER_TIMESTAMP_EN
  logic [MCNT_W-1:0] r_ts;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) r_ts <= '0;
    else            r_ts <= r_ts + 1'b1;
  end

  assign w_payload = r_ts;
`else
  assign w_payload = r_mcnt;
`endif

  // Accept and marker load are mutually exclusive (PASS vs MARK).
  assign w_load      = w_accept || w_mark_load;
  assign w_load_data = w_mark_load ? make_marker(MARK_HDR, w_payload) : IN_DATA;

  tagger_out_stage u_out (
    .i_clk       (BUS_CLK),
    .i_rst_n     (BUS_RST_N),
    .i_load      (w_load),
    .i_data      (w_load_data),
    .i_out_ready (OUT_READY),
    .o_valid     (OUT_VALID),
    .o_data      (OUT_DATA),
    .o_free      (w_free)
  );

  assign IN_READY   = w_in_ready;
  assign MARK_COUNT = r_mcnt;

endmodule
